// File: rtl/signed_msub_div_if.sv
// Operand/result handshake bundle for signed_msub_div.
// The slave modport is the divider side; the master modport is the producer/consumer side.
interface signed_msub_div_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] n;
  logic [31:0] c;
  logic [15:0] d;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] q;
  logic [15:0] r;
  logic        dz;

  modport slave (
    input  in_valid, n, c, d, out_ready,
    output in_ready, out_valid, q, r, dz
  );

  modport master (
    output in_valid, n, c, d, out_ready,
    input  in_ready, out_valid, q, r, dz
  );
endinterface

// File: rtl/signed_msub_div.sv
// Sequential signed (n - c) / d: restoring divider, one quotient bit per cycle.
// Optional macro SIGNED_MSUB_DIV_ZDET_EN enables the divide-by-zero fast path (dz flag).
module signed_msub_div (
  input logic               clk,
  input logic               rst_n,
  signed_msub_div_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ITER  = 3'd2,
    SIGN  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_r;
  logic [31:0] n_r;
  logic [31:0] c_r;
  logic [15:0] d_r;
  logic [32:0] dvd_r;      // |D| shifting out, quotient bits shifting in
  logic [15:0] div_r;
  logic [15:0] rem_r;
  logic [5:0]  cnt_r;
  logic        qneg_r;
  logic        rneg_r;
  logic        zero_r;
  logic [15:0] dlow_r;
  logic [32:0] q_r;
  logic [15:0] r_r;
  logic        dz_r;
  logic        out_valid_r;
  logic        in_ready_r;

  logic [32:0] diff_s;
  logic [32:0] abs_diff_s;
  logic [15:0] abs_d_s;
  logic [16:0] trial_s;
  logic [16:0] rem_nxt_s;
  logic        ge_s;
  logic        zdet_s;

`ifdef SIGNED_MSUB_DIV_ZDET_EN
  assign zdet_s = zero_r;
`else
  assign zdet_s = 1'b0;
`endif

  // Difference, magnitudes and one restoring-division step.
  always_comb begin
    diff_s     = {n_r[31], n_r} - {c_r[31], c_r};
    abs_diff_s = diff_s;
    abs_d_s    = d_r;
    ge_s       = 1'b0;
    trial_s    = {rem_r, dvd_r[32]};
    rem_nxt_s  = trial_s;
    if (diff_s[32]) begin
      abs_diff_s = 33'd0 - diff_s;
    end else begin
      abs_diff_s = diff_s;
    end
    if (d_r[15]) begin
      abs_d_s = 16'd0 - d_r;
    end else begin
      abs_d_s = d_r;
    end
    if (trial_s >= {1'b0, div_r}) begin
      ge_s      = 1'b1;
      rem_nxt_s = trial_s - {1'b0, div_r};
    end else begin
      ge_s      = 1'b0;
      rem_nxt_s = trial_s;
    end
  end

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      n_r         <= 32'd0;
      c_r         <= 32'd0;
      d_r         <= 16'd0;
      dvd_r       <= 33'd0;
      div_r       <= 16'd0;
      rem_r       <= 16'd0;
      cnt_r       <= 6'd0;
      qneg_r      <= 1'b0;
      rneg_r      <= 1'b0;
      zero_r      <= 1'b0;
      dlow_r      <= 16'd0;
      q_r         <= 33'd0;
      r_r         <= 16'd0;
      dz_r        <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            n_r        <= bus.n;
            c_r        <= bus.c;
            d_r        <= bus.d;
            dz_r       <= 1'b0;
            in_ready_r <= 1'b0;
            state_r    <= SETUP;
          end else begin
            state_r    <= IDLE;
          end
        end
        SETUP: begin
          dvd_r   <= abs_diff_s;
          div_r   <= abs_d_s;
          rem_r   <= 16'd0;
          rneg_r  <= diff_s[32];
          qneg_r  <= diff_s[32] ^ d_r[15];
          zero_r  <= (d_r == 16'd0);
          dlow_r  <= diff_s[15:0];
          cnt_r   <= 6'd32;
          state_r <= ITER;
        end
        ITER: begin
          if (zdet_s) begin
            // Zero divisor: publish the fixed result without iterating.
            q_r         <= 33'h1FFFFFFFF;
            r_r         <= dlow_r;
            dz_r        <= 1'b1;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            rem_r <= rem_nxt_s[15:0];
            dvd_r <= {dvd_r[31:0], ge_s};
            if (cnt_r == 6'd0) begin
              state_r <= SIGN;
            end else begin
              cnt_r   <= cnt_r - 6'd1;
            end
          end
        end
        SIGN: begin
          if (zero_r) begin
            q_r <= 33'h1FFFFFFFF;
            r_r <= dlow_r;
          end else begin
            q_r <= qneg_r ? (33'd0 - dvd_r) : dvd_r;
            r_r <= rneg_r ? (16'd0 - rem_r) : rem_r;
          end
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.q         = q_r;
  assign bus.r         = r_r;
  assign bus.dz        = dz_r;

endmodule

// File: tb/tb_signed_msub_div.sv
// Directed-vector bench for signed_msub_div: table of operands with hand-computed results
// plus hand-written hold, back-pressure and mid-operation reset sequences.
module tb_signed_msub_div;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  signed_msub_div_if bus();

  signed_msub_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] n;
    logic [31:0] c;
    logic [15:0] d;
    logic [32:0] q;
    logic [15:0] r;
  } vec_t;

  vec_t vecs [9];

`ifdef SIGNED_MSUB_DIV_ZDET_EN
  localparam int ZLAT = 2;
  localparam logic ZDZ = 1'b1;
`else
  localparam int ZLAT = 35;
  localparam logic ZDZ = 1'b0;
`endif

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present operands, wait for the result and check latency and values.
  task automatic run_op(input logic [31:0] n, input logic [31:0] c, input logic [15:0] d,
                        input int lat, input logic [32:0] eq, input logic [15:0] er,
                        input logic edz);
    int edges;
    int waits;
    waits = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    chk("in_ready_before_op", {32'd0, bus.in_ready}, 33'd1);
    bus.n = n;
    bus.c = c;
    bus.d = d;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("in_ready_after_accept", {32'd0, bus.in_ready}, 33'd0);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (bus.out_valid !== 1'b1 && edges < 100);
    chk("latency", edges, lat);
    chk("q", bus.q, eq);
    chk("r", {17'd0, bus.r}, {17'd0, er});
    chk("dz", {32'd0, bus.dz}, {32'd0, edz});
    if (bus.out_ready === 1'b1) begin
      @(posedge clk);
      #1;
      chk("out_valid_one_cycle", {32'd0, bus.out_valid}, 33'd0);
      chk("in_ready_after_done", {32'd0, bus.in_ready}, 33'd1);
    end
  endtask

  initial begin
    logic [32:0] hq;
    logic [15:0] hr;
    int lat;
    logic edz;
    checks = 0;
    errors = 0;

    vecs[0] = '{32'd100, 32'd4, 16'd7, 33'd13, 16'd5};
    vecs[1] = '{-32'sd100, 32'd4, 16'd7, -33'sd14, -16'sd6};
    vecs[2] = '{32'd100, 32'd4, -16'sd7, -33'sd13, 16'd5};
    vecs[3] = '{32'h7FFFFFFF, 32'h80000000, 16'd1, 33'h0FFFFFFFF, 16'd0};
    vecs[4] = '{32'h80000000, 32'h7FFFFFFF, 16'h8000, 33'd131071, -16'sd32767};
    vecs[5] = '{32'd50, 32'd0, 16'd5, 33'd10, 16'd0};
    vecs[6] = '{32'd9, 32'd2, 16'd0, 33'h1FFFFFFFF, 16'd7};
    vecs[7] = '{32'hFFFFFFFF, 32'd0, 16'd2, 33'd0, 16'hFFFF};
    vecs[8] = '{32'd0, 32'd0, 16'd3, 33'd0, 16'd0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.n = 32'd0;
    bus.c = 32'd0;
    bus.d = 16'd0;
    #23;
    chk("rst_in_ready", {32'd0, bus.in_ready}, 33'd1);
    chk("rst_out_valid", {32'd0, bus.out_valid}, 33'd0);
    chk("rst_q", bus.q, 33'd0);
    chk("rst_r", {17'd0, bus.r}, 33'd0);
    chk("rst_dz", {32'd0, bus.dz}, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      lat = (vecs[i].d == 16'd0) ? ZLAT : 35;
      edz = (vecs[i].d == 16'd0) ? ZDZ : 1'b0;
      run_op(vecs[i].n, vecs[i].c, vecs[i].d, lat, vecs[i].q, vecs[i].r, edz);
    end

    // Back-pressure: result held while in_valid toggles.
    bus.out_ready = 1'b0;
    run_op(32'd100, 32'd4, 16'd7, 35, 33'd13, 16'd5, 1'b0);
    hq = bus.q;
    hr = bus.r;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.in_valid = k[0];
      bus.n = 32'd1000 + k;
      @(posedge clk);
      #1;
      chk("hold_q", bus.q, hq);
      chk("hold_r", {17'd0, bus.r}, {17'd0, hr});
      chk("hold_in_ready", {32'd0, bus.in_ready}, 33'd0);
      chk("hold_out_valid", {32'd0, bus.out_valid}, 33'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", {32'd0, bus.in_ready}, 33'd1);
    chk("release_out_valid", {32'd0, bus.out_valid}, 33'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;

    // Reset during ITER aborts the operation immediately.
    bus.n = 32'd1000;
    bus.c = 32'd0;
    bus.d = 16'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {32'd0, bus.out_valid}, 33'd0);
    chk("abort_in_ready", {32'd0, bus.in_ready}, 33'd1);
    chk("abort_q", bus.q, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd50, 32'd0, 16'd5, 35, 33'd10, 16'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/signed_msub_div.md
SIGNED_MSUB_DIV -- requirements
Module: signed_msub_div

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  an operand set is presented.
REQ-005 in_ready  output  1  the block can accept operands.
REQ-006 n  input  32  signed minuend (accumulated product-sum).
REQ-007 c  input  32  signed addend to remove.
REQ-008 d  input  16  signed divisor.
REQ-009 out_valid  output  1  the result is held on q/r/dz.
REQ-010 out_ready  input  1  the consumer takes the result.
REQ-011 q  output  33  signed quotient (n - c) / d, truncated toward zero.
REQ-012 r  output  16  signed remainder; it carries the sign of (n - c).
REQ-013 dz  output  1  divide-by-zero flag.

Function
REQ-014 The block SHALL be an FSM with states IDLE, SETUP, ITER, SIGN and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 An accept edge is any rising edge with in_valid=1 in IDLE; at that edge n, c and d SHALL be registered and the state SHALL go to SETUP.
REQ-016 In IDLE with in_valid=0, the block SHALL stay in IDLE.
REQ-017 SETUP SHALL form the 33-bit signed difference D = sext(n) - sext(c) with no overflow, then latch |D|, |d|, sign(D) and sign(D) xor sign(d); the next state SHALL be ITER with a bit counter of 32.
REQ-018 ITER SHALL run unsigned restoring division of |D| by |d|, one quotient bit per cycle, MSB first, for exactly 33 cycles; the next state SHALL be SIGN.
REQ-019 SIGN SHALL negate the quotient if sign(D) xor sign(d) is 1, negate the remainder if sign(D) is 1, load q and r, and go to DONE.
REQ-020 In DONE, out_valid SHALL be 1; out_valid SHALL rise on the 35th rising edge after the accept edge.
REQ-021 q, r and dz SHALL be stable while out_valid=1 and out_ready=0; in_valid SHALL be ignored while not in IDLE.
REQ-022 On an edge in DONE with out_ready=1, the state SHALL go to IDLE; no new operands SHALL be accepted on that same edge.
REQ-023 Arithmetic SHALL NOT overflow: |q| <= 2^32-1 fits in 33 bits signed, and |r| <= 32767 fits in 16 bits signed.
REQ-024 For d=0, the result SHALL be q = 33'h1FFFFFFFF (-1) and r = D[15:0] in both configurations; dz=1 only when REQ-031 applies, otherwise dz=0.

Reset
REQ-025 While rst_n=0, the state SHALL be IDLE and all outputs and internal registers SHALL be cleared.
REQ-026 Reset SHALL take effect immediately, without waiting for a clock edge.
REQ-027 Reset values: in_ready=1, out_valid=0, q=0, r=0, dz=0.
REQ-028 Reset SHALL abort any operation in SETUP, ITER, SIGN or DONE; no partial result SHALL appear afterwards.
REQ-029 The first accept SHALL be possible on the first rising edge after rst_n returns to 1.

Configuration
REQ-030 The macro SIGNED_MSUB_DIV_ZDET_EN SHALL select the divide-by-zero fast path.
REQ-031 With SIGNED_MSUB_DIV_ZDET_EN defined: if |d|=0 in SETUP, the block SHALL skip ITER and SIGN, load the REQ-024 result with dz=1, and go to DONE, so out_valid rises on the 2nd edge after accept.
REQ-032 Without SIGNED_MSUB_DIV_ZDET_EN: d=0 SHALL take the full 35-cycle path, SIGN SHALL force the REQ-024 result, dz SHALL remain 0 always, and the port list SHALL be unchanged.

Verification
REQ-033 n=100, c=4, d=7, out_ready=1 -> q=13, r=5, dz=0; out_valid high exactly 35 edges after accept, for one cycle.
REQ-034 n=-100, c=4, d=7 -> q=-14, r=-6; and n=100, c=4, d=-7 -> q=-13, r=5.
REQ-035 n=32'h7FFFFFFF, c=32'h80000000, d=1 -> q=33'h0FFFFFFFF, r=0; n=32'h80000000, c=32'h7FFFFFFF, d=-32768 -> q=131071, r=-32767.
REQ-036 Hold out_ready=0 for 10 cycles after out_valid while toggling in_valid -> q/r stay constant, in_ready=0, no accept; set out_ready=1 -> IDLE next edge, in_ready=1.
REQ-037 Pull rst_n low during ITER cycle 10 -> out_valid=0 and in_ready=1 immediately; after release, n=50, c=0, d=5 -> q=10, r=0 after 35 edges.
REQ-038 n=9, c=2, d=0 -> q=-1, r=7; with the macro: dz=1 and out_valid at edge 2; without it: dz=0 and out_valid at edge 35.
